// File: rtl/acc_cpu_mc.sv
// acc_cpu_mc: multi-cycle accumulator CPU with req/ack handshaked instruction and data ports.
// One FSM register sequences BOOT/FETCH/EXEC/MEM/HALT; memory requests decode from it.
module acc_cpu_mc #(
   parameter int DW = 8,
   parameter int AW = 5
) (
   input  logic          clk_i,
   input  logic          rst_i,
   output logic          imem_req_o,
   output logic [AW-1:0] imem_addr_o,
   input  logic          imem_ack_i,
   input  logic [AW+3:0] imem_data_i,
   output logic          dmem_req_o,
   output logic          dmem_we_o,
   output logic [AW-1:0] dmem_addr_o,
   output logic [DW-1:0] dmem_wdata_o,
   input  logic          dmem_ack_i,
   input  logic [DW-1:0] dmem_rdata_i,
   output logic [DW-1:0] acc_o,
   output logic [2:0]    sw_o,
   output logic [AW-1:0] pc_o,
   output logic [AW+3:0] ir_o,
   output logic          retire_o,
   output logic          halt_o
);
   localparam int IW = 4 + AW;

   typedef enum logic [2:0] {S_BOOT, S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;
   typedef enum logic [3:0] {
      OP_NOP, OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR,  OP_XOR,
      OP_LDI, OP_JMP, OP_JZ,  OP_JN,  OP_JC,  OP_SHL, OP_NOT, OP_HLT
   } op_t;

   state_t        state_q;
   logic          boot_q;
   logic [DW-1:0] acc_q;
   logic [2:0]    sw_q;
   logic [AW-1:0] pc_q;
   logic [IW-1:0] ir_q;
   logic          retire_q;

   op_t           op;
   logic [AW-1:0] opnd;
   logic          is_mem;
   logic          take_jmp;
   logic [DW:0]   sum;
   logic [DW-1:0] acc_d;
   logic          c_d;
   logic [2:0]    sw_d;

   assign op     = op_t'(ir_q[IW-1:AW]);
   assign opnd   = ir_q[AW-1:0];
   assign is_mem = (op >= OP_LDA) && (op <= OP_XOR);

   // Result of the decoded op; EXEC uses it for register ops, MEM once rdata is acked.
   always_comb begin
      sum      = {1'b0, acc_q} + {1'b0, dmem_rdata_i};
      acc_d    = acc_q;
      c_d      = sw_q[2];
      take_jmp = 1'b0;
      case (op)
         OP_LDA: acc_d = dmem_rdata_i;
         OP_ADD: {c_d, acc_d} = sum;
         OP_SUB: begin
            acc_d = acc_q - dmem_rdata_i;
            c_d   = (acc_q < dmem_rdata_i);
         end
         OP_AND: acc_d = acc_q & dmem_rdata_i;
         OP_OR:  acc_d = acc_q | dmem_rdata_i;
         OP_XOR: acc_d = acc_q ^ dmem_rdata_i;
         OP_LDI: acc_d = DW'(opnd);
         OP_JMP: take_jmp = 1'b1;
         OP_JZ:  take_jmp = sw_q[0];
         OP_JN:  take_jmp = sw_q[1];
         OP_JC:  take_jmp = sw_q[2];
         OP_SHL: begin
            acc_d = {acc_q[DW-2:0], 1'b0};
            c_d   = acc_q[DW-1];
         end
         OP_NOT: acc_d = ~acc_q;
         default: ;
      endcase
      sw_d = {c_d, acc_d[DW-1], ~|acc_d};
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= S_BOOT;
         boot_q   <= 1'b0;
         acc_q    <= '0;
         sw_q     <= '0;
         pc_q     <= '0;
         ir_q     <= '0;
         retire_q <= 1'b0;
      end else begin
         retire_q <= 1'b0;
         case (state_q)
            // The edge that ends the reset cycle is absorbed, so BOOT spans one full cycle.
            S_BOOT: begin
               boot_q <= 1'b1;
               if (boot_q) state_q <= S_FETCH;
            end
            S_FETCH: if (imem_ack_i) begin
               ir_q    <= imem_data_i;
               pc_q    <= pc_q + AW'(1);
               state_q <= S_EXEC;
            end
            S_EXEC: begin
               if (is_mem) begin
                  state_q <= S_MEM;
               end else begin
                  retire_q <= 1'b1;
                  state_q  <= (op == OP_HLT) ? S_HALT : S_FETCH;
                  if (take_jmp) pc_q <= opnd;
                  if (op inside {OP_LDI, OP_SHL, OP_NOT}) begin
                     acc_q <= acc_d;
                     sw_q  <= sw_d;
                  end
               end
            end
            S_MEM: if (dmem_ack_i) begin
               retire_q <= 1'b1;
               state_q  <= S_FETCH;
               if (op != OP_STA) begin
                  acc_q <= acc_d;
                  sw_q  <= sw_d;
               end
            end
            S_HALT: ;
            default: state_q <= S_BOOT;
         endcase
      end
   end

   assign imem_req_o   = (state_q == S_FETCH);
   assign imem_addr_o  = pc_q;
   assign dmem_req_o   = (state_q == S_MEM);
   assign dmem_we_o    = (state_q == S_MEM) && (op == OP_STA);
   assign dmem_addr_o  = opnd;
   assign dmem_wdata_o = acc_q;
   assign acc_o        = acc_q;
   assign sw_o         = sw_q;
   assign pc_o         = pc_q;
   assign ir_o         = ir_q;
   assign retire_o     = retire_q;
   assign halt_o       = (state_q == S_HALT);
endmodule

// File: tb/tb_acc_cpu_mc.sv
// Bench for acc_cpu_mc: vector table, hand sequences for timing corners, and random
// programs checked at every retire against an instruction-level reference model.
module tb_acc_cpu_mc;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b0;
   logic       imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire, halt;
   logic [4:0] imem_addr, dmem_addr, pc;
   logic [8:0] imem_data, ir;
   logic [7:0] dmem_wdata, dmem_rdata, acc;
   logic [2:0] sw;

   acc_cpu_mc #(.DW(8), .AW(5)) dut (
      .clk_i(clk), .rst_i(rst),
      .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ack_i(imem_ack), .imem_data_i(imem_data),
      .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata),
      .dmem_ack_i(dmem_ack), .dmem_rdata_i(dmem_rdata),
      .acc_o(acc), .sw_o(sw), .pc_o(pc), .ir_o(ir), .retire_o(retire), .halt_o(halt));

   // Wide instance: zero-wait memories with same-cycle acks.
   logic        rst2 = 1'b0;
   logic        imem_req2, dmem_req2, dmem_we2, retire2, halt2;
   logic [7:0]  imem_addr2, dmem_addr2, pc2;
   logic [11:0] imem_data2, ir2;
   logic [15:0] dmem_wdata2, dmem_rdata2, acc2;
   logic [2:0]  sw2;
   logic [11:0] imem2 [256];
   logic [15:0] dmem2 [256];
   int          maxaddr2 = 0;

   acc_cpu_mc #(.DW(16), .AW(8)) dut2 (
      .clk_i(clk), .rst_i(rst2),
      .imem_req_o(imem_req2), .imem_addr_o(imem_addr2), .imem_ack_i(imem_req2), .imem_data_i(imem_data2),
      .dmem_req_o(dmem_req2), .dmem_we_o(dmem_we2), .dmem_addr_o(dmem_addr2), .dmem_wdata_o(dmem_wdata2),
      .dmem_ack_i(dmem_req2), .dmem_rdata_i(dmem_rdata2),
      .acc_o(acc2), .sw_o(sw2), .pc_o(pc2), .ir_o(ir2), .retire_o(retire2), .halt_o(halt2));

   assign imem_data2  = imem2[imem_addr2];
   assign dmem_rdata2 = dmem2[dmem_addr2];
   always @(posedge clk) begin
      if (dmem_req2 && dmem_we2) dmem2[dmem_addr2] = dmem_wdata2;
      if (imem_req2 && int'(imem_addr2) > maxaddr2) maxaddr2 = int'(imem_addr2);
   end

   // Memory model for the default instance: programmable wait states and stray acks.
   logic [8:0] imem [32];
   logic [7:0] dmem [32];
   int  i_delay = 0, d_delay = 0, i_lat = 0, d_lat = 0, icnt = 0, dcnt = 0, writes = 0;
   bit  rand_wait = 0, stray = 0;
   int  cyc = 0;

   always @(negedge clk) begin
      if (imem_req) begin
         imem_ack  = (icnt >= i_lat);
         imem_data = imem_ack ? imem[imem_addr] : 9'($urandom);
         icnt++;
      end else begin
         imem_ack  = stray && ($urandom_range(0, 1) == 1);
         imem_data = 9'($urandom);
      end
      if (dmem_req) begin
         dmem_ack   = (dcnt >= d_lat);
         dmem_rdata = (dmem_ack && !dmem_we) ? dmem[dmem_addr] : 8'($urandom);
         dcnt++;
      end else begin
         dmem_ack   = stray && ($urandom_range(0, 1) == 1);
         dmem_rdata = 8'($urandom);
      end
   end

   always @(posedge clk) begin
      cyc++;
      if (!rst) begin
         icnt = 0;
         dcnt = 0;
      end else begin
         if (imem_req && imem_ack) begin
            icnt  = 0;
            i_lat = rand_wait ? int'($urandom_range(0, 3)) : i_delay;
         end
         if (dmem_req && dmem_ack) begin
            if (dmem_we) begin
               dmem[dmem_addr] = dmem_wdata;
               writes++;
            end
            dcnt  = 0;
            d_lat = rand_wait ? int'($urandom_range(0, 3)) : d_delay;
         end
      end
   end

   int n_cmp = 0, n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_lat(input int il, input int dl);
      i_delay = il; d_delay = dl; i_lat = il; d_lat = dl;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 32; i++) begin
         imem[i] = {4'hF, 5'd0};
         dmem[i] = 8'h00;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic wait_retire(input string name, output int t);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!retire && k < 300);
      if (!retire) check({name, "_timeout"}, 0, 1);
      t = cyc;
   endtask

   task automatic wait_halt(input string name);
      int k = 0;
      while (!halt && k < 500) begin
         @(negedge clk);
         k++;
      end
      if (!halt) check({name, "_halt_timeout"}, 0, 1);
   endtask

   // Instruction-level reference model.
   int m_imem [32];
   int m_dmem [32];
   int m_acc, m_pc;
   bit m_c, m_n, m_z, m_halted;

   function automatic void m_set(input int v);
      m_acc = v;
      m_z   = (v == 0);
      m_n   = (v >= 128);
   endfunction

   function automatic void m_step();
      int ins, o, x, v;
      ins  = m_imem[m_pc];
      o    = ins / 32;
      x    = ins % 32;
      v    = m_dmem[x];
      m_pc = (m_pc + 1) % 32;
      case (o)
         1:  m_set(v);
         2:  m_dmem[x] = m_acc;
         3:  begin m_c = (m_acc + v) > 255; m_set((m_acc + v) % 256); end
         4:  begin m_c = m_acc < v; m_set((m_acc - v + 256) % 256); end
         5:  m_set(m_acc & v);
         6:  m_set(m_acc | v);
         7:  m_set(m_acc ^ v);
         8:  m_set(x);
         9:  m_pc = x;
         10: if (m_z) m_pc = x;
         11: if (m_n) m_pc = x;
         12: if (m_c) m_pc = x;
         13: begin m_c = m_acc >= 128; m_set((m_acc * 2) % 256); end
         14: m_set(255 - m_acc);
         15: m_halted = 1;
         default: ;
      endcase
   endfunction

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] eacc;
      logic [2:0] esw;
   } vec_t;

   vec_t vecs [13];

   initial begin
      int t0, r1, r2, r3, k, ok, bad;
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, r1, r2, r3, k, ok, bad, nret;

      // {op, LDA value, operand value, expected acc, expected {C,N,Z}}
      vecs[0]  = '{4'h3, 8'h05, 8'hFE, 8'h03, 3'b100};
      vecs[1]  = '{4'h4, 8'h03, 8'h04, 8'hFF, 3'b110};
      vecs[2]  = '{4'h4, 8'h10, 8'h10, 8'h00, 3'b001};
      vecs[3]  = '{4'h5, 8'hF0, 8'h3C, 8'h30, 3'b000};
      vecs[4]  = '{4'h6, 8'h80, 8'h01, 8'h81, 3'b010};
      vecs[5]  = '{4'h7, 8'hAA, 8'hAA, 8'h00, 3'b001};
      vecs[6]  = '{4'hD, 8'h81, 8'h00, 8'h02, 3'b100};
      vecs[7]  = '{4'hE, 8'h0F, 8'h00, 8'hF0, 3'b010};
      vecs[8]  = '{4'h3, 8'h80, 8'h80, 8'h00, 3'b101};
      vecs[9]  = '{4'h1, 8'h00, 8'h7F, 8'h7F, 3'b000};
      vecs[10] = '{4'hD, 8'h40, 8'h00, 8'h80, 3'b010};
      vecs[11] = '{4'h0, 8'h00, 8'h55, 8'h00, 3'b001};
      vecs[12] = '{4'h4, 8'h00, 8'h01, 8'hFF, 3'b110};

      // Reset, boot timing and zero-wait latency.
      set_lat(0, 0);
      clear_mem();
      imem[0] = {4'h8, 5'd5};
      imem[1] = {4'h3, 5'd3};
      imem[2] = {4'h4, 5'd4};
      dmem[3] = 8'hFE;
      dmem[4] = 8'h04;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outs", int'({acc, sw, pc, ir, imem_req, dmem_req, dmem_we, retire, halt}), 0);
      rst = 1'b1;
      @(negedge clk);
      check("boot_req_edge1", int'(imem_req), 0);
      @(negedge clk);
      check("boot_req_edge2", int'(imem_req), 1);
      check("boot_addr", int'(imem_addr), 0);
      t0 = cyc;
      wait_retire("ldi", r1);
      check("lat_ldi", r1 - t0, 2);
      wait_retire("add", r2);
      check("lat_add", r2 - r1, 3);
      check("add_acc", int'(acc), 'h03);
      check("add_sw", int'(sw), 3'b100);
      wait_retire("sub", r3);
      check("lat_sub", r3 - r2, 3);
      check("sub_acc", int'(acc), 'hFF);
      check("sub_sw", int'(sw), 3'b110);

      // Vector table: LDA [1]; op [2]; HLT.
      for (int v = 0; v < 13; v++) begin
         clear_mem();
         imem[0] = {4'h1, 5'd1};
         imem[1] = {vecs[v].op, 5'd2};
         dmem[1] = vecs[v].a;
         dmem[2] = vecs[v].b;
         do_reset();
         wait_halt($sformatf("vec%0d", v));
         check($sformatf("vec%0d_acc", v), int'(acc), int'(vecs[v].eacc));
         check($sformatf("vec%0d_sw", v), int'(sw), int'(vecs[v].esw));
      end

      // Store held through 4 wait cycles.
      set_lat(0, 4);
      clear_mem();
      imem[0] = {4'h8, 5'h1A};
      imem[1] = {4'h2, 5'd7};
      writes  = 0;
      do_reset();
      k = 0;
      while (!dmem_req && k < 50) begin
         @(negedge clk);
         k++;
      end
      ok = 1;
      k  = 0;
      while (dmem_req && k < 20) begin
         if (!(dmem_we === 1'b1 && dmem_addr === 5'd7 && dmem_wdata === 8'h1A)) ok = 0;
         k++;
         @(negedge clk);
      end
      check("sta_hold", ok, 1);
      check("sta_cycles", k, 5);
      wait_halt("sta");
      check("sta_writes", writes, 1);
      check("sta_mem", int'(dmem[7]), 'h1A);
      check("sta_acc_sw", int'({acc, sw}), int'({8'h1A, 3'b000}));
      set_lat(0, 0);

      // Branching and pc wrap.
      clear_mem();
      imem[0]  = {4'h8, 5'd0};
      imem[1]  = {4'hA, 5'h10};
      imem[16] = {4'h8, 5'd1};
      imem[17] = {4'hA, 5'd0};
      imem[18] = {4'h9, 5'd31};
      imem[31] = {4'h0, 5'd0};
      do_reset();
      wait_retire("b1", r1);
      wait_retire("b2", r1);
      check("jz_taken_pc", int'(pc), 'h10);
      wait_retire("b3", r1);
      wait_retire("b4", r1);
      check("jz_not_taken_pc", int'(pc), 'h12);
      wait_retire("b5", r1);
      check("jmp_pc", int'(pc), 31);
      wait_retire("b6", r1);
      check("pc_wrap", int'(pc), 0);

      // Jump-to-self retires every two cycles.
      clear_mem();
      imem[0] = {4'h9, 5'd0};
      do_reset();
      wait_retire("self1", r1);
      wait_retire("self2", r2);
      wait_retire("self3", r3);
      check("self_gap", (r2 - r1) * 16 + (r3 - r2), 'h22);
      check("self_pc", int'(pc), 0);

      // Halt ignores stray acks.
      clear_mem();
      imem[0] = {4'h8, 5'd3};
      do_reset();
      wait_halt("hlt");
      stray = 1;
      ok = 1;
      repeat (20) begin
         @(negedge clk);
         if (!(imem_req === 1'b0 && dmem_req === 1'b0 && retire === 1'b0 && halt === 1'b1
               && acc === 8'd3 && pc === 5'd2)) ok = 0;
      end
      check("halt_quiet", ok, 1);
      stray = 0;

      // Reset during a stalled data read.
      set_lat(0, 100);
      clear_mem();
      imem[0] = {4'h8, 5'd7};
      imem[1] = {4'h1, 5'd1};
      dmem[1] = 8'h99;
      do_reset();
      k = 0;
      while (!dmem_req && k < 50) begin
         @(negedge clk);
         k++;
      end
      repeat (3) @(negedge clk);
      check("midrst_pre_req", int'(dmem_req), 1);
      #2 rst = 1'b0;
      #1;
      check("midrst_req_drop", int'(dmem_req), 0);
      check("midrst_retire", int'(retire), 0);
      check("midrst_acc", int'(acc), 0);
      @(negedge clk);
      rst = 1'b1;
      set_lat(0, 0);

      // Random programs against the reference model.
      for (int run = 0; run < 6; run++) begin
         rand_wait = 1;
         stray     = 1;
         for (int i = 0; i < 32; i++) begin
            int o;
            o = int'($urandom_range(0, 15));
            if (o == 15 && $urandom_range(0, 3) != 0) o = 0;
            imem[i]   = {4'(o), 5'($urandom)};
            dmem[i]   = 8'($urandom);
            m_imem[i] = int'(imem[i]);
            m_dmem[i] = int'(dmem[i]);
         end
         m_acc = 0; m_pc = 0; m_c = 0; m_n = 0; m_z = 0; m_halted = 0;
         do_reset();
         nret = 0;
         k    = 0;
         while (k < 4000 && nret < 150 && !(m_halted && halt)) begin
            @(negedge clk);
            k++;
            if (retire) begin
               m_step();
               nret++;
               check("rnd_acc", int'(acc), m_acc);
               check("rnd_sw", int'(sw), int'({m_c, m_n, m_z}));
               check("rnd_pc", int'(pc), m_pc);
               check("rnd_halt", int'(halt), int'(m_halted));
            end
         end
         if (k >= 4000) check("rnd_timeout", 0, 1);
         bad = 0;
         for (int i = 0; i < 32; i++)
            if (int'(dmem[i]) != m_dmem[i]) bad++;
         check("rnd_dmem", bad, 0);
      end
      rand_wait = 0;
      stray     = 0;

      // Wide instance: 16-bit data, 8-bit addresses.
      for (int i = 0; i < 256; i++) begin
         imem2[i] = {4'hF, 8'h00};
         dmem2[i] = 16'h0000;
      end
      imem2[0]     = {4'h9, 8'hF0};
      imem2[8'hF0] = {4'h8, 8'hFF};
      imem2[8'hF1] = {4'h3, 8'h80};
      dmem2[8'h80] = 16'hFF01;
      rst2 = 1'b0;
      repeat (3) @(negedge clk);
      rst2 = 1'b1;
      k = 0;
      while (!halt2 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("w_halt", int'(halt2), 1);
      check("w_acc", int'(acc2), 0);
      check("w_sw", int'(sw2), 3'b101);
      check("w_pc", int'(pc2), 'hF3);
      check("w_ir", int'(ir2), 'hF00);
      check("w_maxaddr", maxaddr2, 'hF2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
